// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified memory port handshake between the controller (master) and the
// instruction/data memory (slave).
interface mc_mem_if;
    logic mem_req;
    logic mem_ready;
    logic mem_write;
    logic iord;

    modport master (output mem_req, output mem_write, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_write, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_controller_aludec.sv
// R-type funct decoder: ALU operation plus a flag saying the funct is supported.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with retired-instruction counter.
// Define MC_BNE_EN to accept bne (op 000101) as a branch with inverted condition.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    mc_mem_if.master         mem,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    logic [2:0] dec_ctrl;
    logic       dec_valid;
    logic       branch_taken;
    logic       req_c;
    logic       write_c;
    logic       iord_c;

    mc_aludec u_aludec (
        .funct       (funct),
        .alu_control (dec_ctrl),
        .valid       (dec_valid)
    );

`ifdef MC_BNE_EN
    logic bne_q;
    assign branch_taken = bne_q ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    // Sequencing, sticky illegal flag and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_FETCH;
            illegal_op  <= 1'b0;
            instr_count <= '0;
`ifdef MC_BNE_EN
            bne_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH:  if (mem.mem_ready) state <= S_DECODE;
                S_DECODE: begin
`ifdef MC_BNE_EN
                    bne_q <= (op == OP_BNE);
`endif
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE: begin
                            if (dec_valid) begin
                                state <= S_EXECUTE;
                            end else begin
                                state      <= S_HALT;
                                illegal_op <= 1'b1;
                            end
                        end
                        OP_BEQ:  state <= S_BRANCH;
`ifdef MC_BNE_EN
                        OP_BNE:  state <= S_BRANCH;
`endif
                        OP_ADDI: state <= S_ADDIEXEC;
                        OP_J:    state <= S_JUMP;
                        default: begin
                            state      <= S_HALT;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem.mem_ready) state <= S_MEMWB;
                S_MEMWR: begin
                    if (mem.mem_ready) begin
                        state       <= S_FETCH;
                        instr_count <= instr_count + CNT_W'(1);
                    end
                end
                S_EXECUTE:  state <= S_ALUWB;
                S_ADDIEXEC: state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                    state       <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Moore decode from state; mem_ready and zero only qualify strobes.
    always_comb begin
        req_c       = 1'b0;
        iord_c      = 1'b0;
        write_c     = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_control = ALU_ADD;
        pc_src      = PC_ALU;
        pc_en       = 1'b0;
        case (state)
            S_FETCH: begin
                req_c     = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem.mem_ready;
                pc_en     = mem.mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                req_c  = 1'b1;
                iord_c = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                req_c   = 1'b1;
                iord_c  = 1'b1;
                write_c = mem.mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = dec_ctrl;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = PC_ALUOUT;
                pc_en       = branch_taken;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            write_c   = 1'b0;
        end
    end

    assign mem.mem_req   = req_c;
    assign mem.iord      = iord_c;
    assign mem.mem_write = write_c;

endmodule
